// File: rtl/demux1a2dosbits_fifo_if.sv
// Splitter-side bundle for the 1:2 two-bit demux:
// one input stream plus two independently popped lanes.
interface demux1a2dosbits_fifo_if #(
   parameter int AW = 2
);
   logic          selector;
   logic          valid_in;
   logic [1:0]    data_in;
   logic          ready_in;
   logic          pop0;
   logic          pop1;
   logic          valid_out0;
   logic [1:0]    data_out0;
   logic          valid_out1;
   logic [1:0]    data_out1;
   logic [AW:0]   count0;
   logic [AW:0]   count1;
   logic          full0;
   logic          full1;
   logic          err_underflow;

   modport master (
      output selector, valid_in, data_in, pop0, pop1,
      input  ready_in, valid_out0, data_out0,
      input  valid_out1, data_out1, count0, count1,
      input  full0, full1, err_underflow
   );

   modport slave (
      input  selector, valid_in, data_in, pop0, pop1,
      output ready_in, valid_out0, data_out0,
      output valid_out1, data_out1, count0, count1,
      output full0, full1, err_underflow
   );
endinterface

// File: rtl/demux1a2dosbits_fifo.sv
// 1:2 demux of a 2-bit valid/data stream into two
// show-ahead lane FIFOs so one stalled consumer never blocks the other.
module demux1a2dosbits_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic                    clk,
   input logic                    reset,
   demux1a2dosbits_fifo_if.slave  bus
);

   logic [1:0]    mem  [2][DEPTH];
   logic [AW-1:0] wptr [2];
   logic [AW-1:0] rptr [2];
   logic [AW:0]   cnt  [2];

   logic [1:0] vld;
   logic [1:0] full;
   logic [1:0] push;
   logic [1:0] pop;
   logic       under;

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         vld[l]  = (cnt[l] != '0);
         full[l] = (cnt[l] == (AW+1)'(DEPTH));
      end
      // a full lane refuses even when it is popped this cycle
      bus.ready_in = bus.selector ? ~full[1] : ~full[0];
      push[0] = bus.valid_in & bus.ready_in & ~bus.selector;
      push[1] = bus.valid_in & bus.ready_in &  bus.selector;
      pop[0]  = bus.pop0 & vld[0];
      pop[1]  = bus.pop1 & vld[1];
      under   = (bus.pop0 & ~vld[0]) | (bus.pop1 & ~vld[1]);
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (push[l]) mem[l][wptr[l]] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int l = 0; l < 2; l++) begin
            wptr[l] <= '0;
            rptr[l] <= '0;
            cnt[l]  <= '0;
         end
         bus.err_underflow <= 1'b0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (push[l]) wptr[l] <= wptr[l] + 1'b1;
            if (pop[l])  rptr[l] <= rptr[l] + 1'b1;
            cnt[l] <= cnt[l] + {{AW{1'b0}}, push[l]}
                             - {{AW{1'b0}}, pop[l]};
         end
         if (under) bus.err_underflow <= 1'b1;
      end
   end

   always_comb begin
      bus.valid_out0 = vld[0];
      bus.valid_out1 = vld[1];
      bus.data_out0  = vld[0] ? mem[0][rptr[0]] : 2'b00;
      bus.data_out1  = vld[1] ? mem[1][rptr[1]] : 2'b00;
      bus.count0     = cnt[0];
      bus.count1     = cnt[1];
      bus.full0      = full[0];
      bus.full1      = full[1];
   end

endmodule

// File: doc/demux1a2dosbits_fifo.md
Name: demux1a2dosbits_fifo

Overview:
- 1:2 demultiplexer for the 2-bit valid/data stream; the inverse of the two-lane 2-bit mux stage.
- Each accepted input word is steered by `selector` into one of two output lanes.
- Each lane has its own FIFO, so one stalled consumer does not block words bound for the other lane.
- Sits at the splitter end of the data path and feeds the two downstream 2-bit consumers.

Parameters:
- DEPTH, 4, entries per lane FIFO; power of 2, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- selector  input  1  lane select for the current input word: 0 selects lane 0, 1 selects lane 1.
- valid_in  input  1  input word present this cycle.
- data_in  input  2  input word.
- ready_in  output  1  the lane chosen by `selector` can accept a word this cycle.
- pop0  input  1  lane-0 consumer takes the head word.
- pop1  input  1  lane-1 consumer takes the head word.
- valid_out0  output  1  lane 0 is non-empty.
- data_out0  output  2  lane-0 head word.
- valid_out1  output  1  lane 1 is non-empty.
- data_out1  output  2  lane-1 head word.
- count0  output  AW+1  lane-0 occupancy.
- count1  output  AW+1  lane-1 occupancy.
- full0  output  1  count0 == DEPTH.
- full1  output  1  count1 == DEPTH.
- err_underflow  output  1  sticky flag: a pop was issued to an empty lane.

Behaviour:
- Reset (reset=1 sampled at a clk edge):
  - All pointers and counts go to 0.
  - valid_out0/1=0, data_out0/1=2'b00, full0/1=0, err_underflow=0.
  - FIFO storage contents are don't-care, but data_outN reads 2'b00 whenever valid_outN=0.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-stream discards all queued words.
- ready_in (combinational):
  - selector=0: ready_in = !full0.
  - selector=1: ready_in = !full1.
  - ready_in is independent of valid_in.
- Push:
  - A word is accepted when valid_in & ready_in at the edge.
  - It is written at the selected lane's write pointer; that write pointer and count increment.
  - A word offered with ready_in=0 is not accepted. The source must hold valid_in/data_in/selector until it is accepted.
- Latency: a word accepted at edge t appears on data_outN with valid_outN=1 after edge t, i.e. one cycle after acceptance, when the lane was empty.
- Output side:
  - The FIFO is show-ahead: data_outN always presents the head word.
  - Pop occurs when popN & valid_outN at the edge; the read pointer increments and the count decrements.
- Simultaneous push and pop on the same lane:
  - Allowed whenever the lane is not full; the count is unchanged and both pointers advance.
  - On a full lane, ready_in=0 even if a pop occurs that cycle (no pass-through). The push is retried the next cycle.
- Pointer wrap: read and write pointers are AW bits and wrap modulo DEPTH with no special handling.
- Lane independence: a push to one lane and a pop from the other in the same cycle both take effect.
- Underflow:
  - popN with valid_outN=0 is ignored (no pointer or count change).
  - It sets err_underflow=1, which holds until reset.
- Ordering: within a lane, output order equals acceptance order. No ordering guarantee between lanes.
- Counts: countN never exceeds DEPTH and never goes below 0.
- All outputs are registered or derived only from registered state. The exception is ready_in, which also depends combinationally on selector.

Test Plan:
- Reset then idle -> all outputs 0, ready_in=1 for both selector values.
- Push 2'b01 to lane 0, then 2'b10 to lane 1 on consecutive cycles -> data_out0=01 one cycle after its accept and data_out1=10 one cycle after its accept; count0=count1=1.
- Push 5 words (00,01,10,11,01) to lane 1 with pop1=0, DEPTH=4 -> the first four are accepted; ready_in=0 on the fifth; full1=1, count1=4. Lane 0 still accepts a word with selector=0.
- Lane 1 full; pop1 and push to lane 1 in the same cycle -> the push is refused that cycle (ready_in=0) and accepted the next cycle. Pops return 00,01,10,11 then the retried 01.
- Stream 10 words alternating lanes with continuous pops -> pointers wrap; output order per lane is preserved; counts stay ≤1.
- pop0 while lane 0 is empty -> no state change and err_underflow=1 thereafter. Assert reset mid-stream with words queued -> counts 0, valid_out0/1=0, err_underflow=0 the next cycle.
